// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_arb_pkg
// Description : Shared constants for the unified-memory port arbiter. It holds
//               the arbiter state encodings and the full-word byte-enable
//               pattern that is used for instruction fetches.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter FSM state encodings
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_DM = 2'd2;

  // Fetches always read the whole word
  localparam logic [3:0] MEM_BE_FULL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : wait_timer
// Description : A loadable 4-bit down-counter that times one memory access.
//               A load takes priority over the count. The counter stops at zero.
// Ports       : clk        - system clock, rising edge
//               reset      - asynchronous reset, active low
//               load       - loads load_value in place of the count
//               load_value - cycles in the access that is starting
//               value      - current count (0 = no access in flight)
//               last       - high in the final cycle of the access (value == 1)
// Revision    : 1.0 - initial release
// ============================================================================
module wait_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic [3:0] value,
  output logic       last
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign last  = (cnt_q == 4'd1);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported, fixed-latency memory between
//               instruction fetch (IF) and MEM-stage data access (DM). Each
//               access takes WAIT_CYCLES cycles. DM has priority. On completion,
//               the arbiter grants the other requester directly. Each requester
//               also receives a stall request.
// Ports       : clk, reset (async, active low)
//               if_req/if_addr/if_kill -> if_rdata/if_ready   fetch port
//               dm_req/dm_we/dm_addr/dm_wdata/dm_be
//                                      -> dm_rdata/dm_ready   data port
//               stall_if, stall_dm                            hazard-unit stalls
//               mem_en/mem_we/mem_addr/mem_wdata/mem_be, mem_rdata  memory side
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_be,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  logic [1:0]        state_q, state_d;
  logic              kill_q, kill_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              grant_if, grant_dm;
  logic              timer_last;
  logic [3:0]        timer_value;
  logic              fetch_killed;

  wait_timer u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (grant_if | grant_dm),
    .load_value (WAIT_LOAD),
    .value      (timer_value),
    .last       (timer_last)
  );

  // A kill that arrives in the final cycle must suppress that same if_ready.
  assign fetch_killed = kill_q | if_kill;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_req) begin
          state_d  = BUSY_DM;
          grant_dm = 1'b1;
        end else if (if_req) begin
          state_d  = BUSY_IF;
          grant_if = 1'b1;
        end
      end
      BUSY_IF: begin
        if (timer_last) begin
          // A killed fetch goes back through IDLE. This gives the re-issued
          // fetch a clean start.
          if (!fetch_killed && dm_req) begin
            state_d  = BUSY_DM;
            grant_dm = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      BUSY_DM: begin
        if (timer_last) begin
          if (if_req) begin
            state_d  = BUSY_IF;
            grant_if = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    // The timer is nonzero exactly while an access is in flight.
    mem_en   = (state_q != IDLE) && (timer_value != 4'd0);
    mem_we   = (state_q == BUSY_DM) && we_q;
    if_ready = (state_q == BUSY_IF) && timer_last && !fetch_killed;
    dm_ready = (state_q == BUSY_DM) && timer_last;
    if_rdata = if_ready ? mem_rdata : '0;
    dm_rdata = dm_ready ? mem_rdata : '0;
    stall_if = if_req & ~if_ready;
    stall_dm = dm_req & ~dm_ready;
  end

  // ---------------- access capture and kill flag ----------------
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    kill_d  = 1'b0;
    if (state_q == BUSY_IF) begin
      kill_d = fetch_killed & ~timer_last;
    end
    if (grant_dm) begin
      addr_d  = dm_addr;
      wdata_d = dm_wdata;
      be_d    = dm_be;
      we_d    = dm_we;
    end else if (grant_if) begin
      addr_d = if_addr;
      be_d   = MEM_BE_FULL;
      we_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kill_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'd0;
    end else begin
      kill_q  <= kill_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. It instantiates one
//               arbiter with WAIT_CYCLES=2 and one with WAIT_CYCLES=1. The
//               bench provides its own memory model. Expected read data enters
//               per-port queues when a request is issued. The data leaves the
//               queue and is compared when the matching ready appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // WAIT_CYCLES = 2 instance
  logic        if_req = 0, if_kill = 0, if_ready, dm_req = 0, dm_we = 0, dm_ready;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, if_rdata, dm_rdata;
  logic [3:0]  dm_be = 0, mem_be;
  logic        stall_if, stall_dm, mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // WAIT_CYCLES = 1 instance
  logic        if_req2 = 0, if_ready2, dm_ready2, stall_if2, stall_dm2, mem_en2, mem_we2;
  logic [31:0] if_addr2 = 0, if_rdata2, dm_rdata2, mem_addr2, mem_wdata2, mem_rdata2;
  logic [3:0]  mem_be2;

  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return (a == 32'h0040_0000) ? 32'h2408_0005 : (a ^ 32'hA5A5_5A5A);
  endfunction

  assign mem_rdata  = mem_en  ? model_rd(mem_addr)  : 32'h0;
  assign mem_rdata2 = mem_en2 ? model_rd(mem_addr2) : 32'h0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req2), .if_addr(if_addr2), .if_kill(1'b0),
    .if_rdata(if_rdata2), .if_ready(if_ready2),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
    .dm_be(4'h0), .dm_rdata(dm_rdata2), .dm_ready(dm_ready2),
    .stall_if(stall_if2), .stall_dm(stall_dm2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_be(mem_be2), .mem_rdata(mem_rdata2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start of the next cycle: 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample point in the middle of the current cycle
  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: compare returned data whenever a ready is seen
  always @(negedge clk) begin
    if (if_ready === 1'b1) begin
      checks++;
      assert (if_q.size() != 0) else begin
        errors++;
        $error("FAIL if_unexpected_ready: observed=1 expected=0");
      end
      if (if_q.size() != 0) check("if_rdata", if_rdata, if_q.pop_front());
    end
    if (dm_ready === 1'b1) begin
      checks++;
      assert (dm_q.size() != 0) else begin
        errors++;
        $error("FAIL dm_unexpected_ready: observed=1 expected=0");
      end
      if (dm_q.size() != 0) check("dm_rdata", dm_rdata, dm_q.pop_front());
    end
  end

  initial begin
    // ---- reset state ----
    cyc(); cyc(); smp();
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ready", {if_ready, dm_ready}, 0);
    cyc(); reset = 1'b1;
    cyc(); smp();

    // ---- 1: single fetch ----
    cyc(); if_addr = 32'h0040_0000; if_req = 1; if_q.push_back(32'h2408_0005);
    smp(); check("t1_stall_t0", stall_if, 1); check("t1_en_t0", mem_en, 0);
    cyc(); smp();
    check("t1_stall_t1", stall_if, 1); check("t1_en_t1", mem_en, 1);
    check("t1_addr", mem_addr, 32'h0040_0000); check("t1_be", mem_be, 4'hF);
    check("t1_ready_t1", if_ready, 0);
    cyc(); smp(); check("t1_ready_t2", if_ready, 1); check("t1_stall_t2", stall_if, 0);
    cyc(); if_req = 0; smp();
    check("t1_en_t3", mem_en, 0); check("t1_rdata_idle", if_rdata, 0);

    // ---- 2: simultaneous requests, DM first ----
    cyc(); if_addr = 32'h0040_0004; if_req = 1;
    dm_addr = 32'h1001_0000; dm_we = 0; dm_req = 1;
    dm_q.push_back(model_rd(32'h1001_0000)); if_q.push_back(model_rd(32'h0040_0004));
    smp(); check("t2_stall_dm_t0", stall_dm, 1);
    cyc(); smp(); check("t2_addr_t1", mem_addr, 32'h1001_0000); check("t2_dmrdy_t1", dm_ready, 0);
    cyc(); smp(); check("t2_dmrdy_t2", dm_ready, 1); check("t2_stall_if_t2", stall_if, 1);
    cyc(); dm_req = 0; smp();
    check("t2_addr_t3", mem_addr, 32'h0040_0004); check("t2_en_t3", mem_en, 1);
    check("t2_ifrdy_t3", if_ready, 0);
    cyc(); smp(); check("t2_ifrdy_t4", if_ready, 1);
    cyc(); if_req = 0; smp(); check("t2_en_t5", mem_en, 0);

    // ---- 3: byte-masked store ----
    cyc(); dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_wdata = 32'hDEAD_BEEF;
    dm_addr = 32'h1001_0008; dm_q.push_back(model_rd(32'h1001_0008));
    smp();
    cyc(); smp();
    check("t3_we_t1", mem_we, 1); check("t3_be_t1", mem_be, 4'b0011);
    check("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc(); smp(); check("t3_we_t2", mem_we, 1); check("t3_dmrdy_t2", dm_ready, 1);
    cyc(); dm_req = 0; dm_we = 0; smp();
    check("t3_we_t3", mem_we, 0); check("t3_en_t3", mem_en, 0);

    // ---- 4: kill an in-flight fetch, then re-issue ----
    cyc(); if_addr = 32'h0040_0008; if_req = 1;
    smp();
    cyc(); if_kill = 1; smp(); check("t4_en_t1", mem_en, 1);
    cyc(); if_kill = 0; smp(); check("t4_ready_t2", if_ready, 0); check("t4_en_t2", mem_en, 1);
    cyc(); if_q.push_back(model_rd(32'h0040_0008)); smp(); check("t4_idle_t3", mem_en, 0);
    cyc(); smp(); check("t4_en_t4", mem_en, 1);
    cyc(); smp(); check("t4_ready_t5", if_ready, 1);
    cyc(); if_req = 0; smp();

    // ---- 5: asynchronous reset mid-store ----
    cyc(); dm_req = 1; dm_we = 1; dm_be = 4'hF; dm_wdata = 32'h1234_5678;
    dm_addr = 32'h1001_0010;
    smp();
    cyc(); smp(); check("t5_en_busy", mem_en, 1); check("t5_we_busy", mem_we, 1);
    #2 reset = 1'b0;
    #1;
    check("t5_en_async", mem_en, 0); check("t5_we_async", mem_we, 0);
    check("t5_dmrdy_async", dm_ready, 0); check("t5_addr_async", mem_addr, 0);
    cyc(); smp(); check("t5_en_inrst", mem_en, 0);
    cyc(); reset = 1'b1; dm_q.push_back(model_rd(32'h1001_0010));
    smp(); check("t5_en_rel", mem_en, 0);
    cyc(); smp(); check("t5_en_regrant", mem_en, 1); check("t5_addr_regrant", mem_addr, 32'h1001_0010);
    cyc(); smp(); check("t5_dmrdy", dm_ready, 1);
    cyc(); dm_req = 0; dm_we = 0; smp();

    // ---- 6: WAIT_CYCLES=1, continuous fetch alternates busy/idle ----
    cyc(); if_addr2 = 32'h0040_0000; if_req2 = 1;
    smp(); check("t6_ready_c0", if_ready2, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc(); smp();
      check($sformatf("t6_ready_c%0d", k), if_ready2, (k % 2 == 1) ? 1 : 0);
      check($sformatf("t6_en_c%0d", k), mem_en2, (k % 2 == 1) ? 1 : 0);
      if (k % 2 == 1) check($sformatf("t6_rdata_c%0d", k), if_rdata2, 32'h2408_0005);
    end
    cyc(); if_req2 = 0; smp();

    // ---- every expected completion arrived ----
    check("if_q_drained", if_q.size(), 0);
    check("dm_q_drained", dm_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
